tpu_mmio_responder: RTL
=======================

// Module: tpu_mmio_responder
// PURPOSE
//  Slave end of the tpuv1 host bus (addr/dataIn/r_w/dataOut/rdValid).
//  Decodes 64-bit word accesses into A-row, B-row, C-half-row writes and C/status reads.
//  Registers one pending write per cycle, with read forwarding.
//  Runs the compute-sequencer FSM that drives the systolic array after a start write.
//  Sits between the AFU host interface and the A/B/C memories and array inside tpuv1.
// PARAMETERS
//  BITS_AB  8   A/B element width
//  BITS_C   16  C element width
//  DIM      8   array dimension; DIM*BITS_AB==DATAW and DIM*BITS_C==2*DATAW required
//  ADDRW    16  byte-address width
//  DATAW    64  bus word width
// PORTS
//  clk       in   1               clock
//  rst       in   1               synchronous reset, active-high
//  addr      in   ADDRW           byte address, 8-byte aligned
//  r_w       in   1               1=write, 0=read
//  dataIn    in   DATAW           write data
//  dataOut   out  DATAW           read data, combinational from addr
//  rdValid   out  1               addr decodes to a readable location and r_w=0
//  a_wr      out  1               A row write strobe (registered)
//  b_wr      out  1               B row write strobe (registered)
//  c_wr      out  1               C half-row write strobe (registered)
//  wr_row    out  $clog2(DIM)     row index for a_wr/b_wr/c_wr
//  wr_half   out  1               C half: 0=cols 0..3, 1=cols 4..7
//  wr_data   out  DATAW           registered write data
//  c_rd_row  out  $clog2(DIM)     C read row, combinational from addr
//  c_rd_half out  1               C read half, combinational from addr
//  c_rdata   in   DATAW           C memory read data for c_rd_row/c_rd_half
//  sa_en     out  1               systolic array / skew feed enable
//  sa_cycle  out  $clog2(3*DIM)   feed cycle index 0..3*DIM-2
//  busy      out  1               compute in progress
//  done      out  1               one-cycle pulse at compute end
// BEHAVIOUR
//  Address map (addr[2:0]!=0 means unmapped):
//   0x100+8r   A row r, write only
//   0x200+8r   B row r, write only
//   0x300+16r+8h  C row r, half h; read/write
//   0x400      write = start; read = {63'b0,busy}
//  Address bounds: r<DIM. Anything else is unmapped; writes are dropped.
//  Unmapped reads: dataOut=0, rdValid=0.
//  Write path:
//   - A write accepted at posedge N asserts exactly one of a_wr/b_wr/c_wr for cycle N+1.
//   - wr_row/wr_half/wr_data stay valid alongside that strobe.
//   - Back-to-back writes are allowed: one per cycle.
//  Forwarding: if c_wr is pending and the current read address equals that
//   row/half, dataOut=wr_data. Otherwise dataOut=c_rdata.
//  FSM IDLE -> FEED -> DONE -> IDLE:
//   - IDLE: a write to 0x400 registers start; next cycle enters FEED with sa_cycle=0.
//   - FEED: sa_en=1 and busy=1. sa_cycle increments each cycle; after value 3*DIM-2 -> DONE.
//   - DONE: done=1 and busy=1 for one cycle, then IDLE.
//   - Start->done latency: 3*DIM+1 cycles (25 at DIM=8), which is below the host wait of 4*DIM.
//  While busy: A/B/C writes and start writes are dropped with no strobe.
//   C reads still return c_rdata.
//  A start written in the same cycle that DONE exits IDLE-bound is dropped.
//  Reset values: all strobes 0, wr_* 0, sa_en 0, sa_cycle 0, busy 0, done 0, state IDLE.
//  Reset asserted mid-FEED: IDLE next cycle, sa_en=0, and no done pulse.
//  Reset also cancels a pending registered write: no strobe issues.
//  dataOut and rdValid are combinational and unaffected by reset, apart from forwarding state.
// TESTING
//  - Reset: hold rst 1 cycle, then read 0x300..0x378 with c_rdata=0.
//    -> dataOut=0, rdValid=1, busy=0, all strobes 0.
//  - Write A 0x108 data 0x0102..08 -> next cycle a_wr=1, wr_row=1, wr_data=0x0102..08.
//    Write B 0x238 -> b_wr=1, wr_row=7.
//  - Write 0x318 data 0xAAAA; read 0x318 the next cycle with c_rdata=0
//    -> dataOut=0xAAAA (forwarded). c_wr=1, wr_row=1, wr_half=1.
//  - Write 0x400 -> sa_en high for 23 cycles, sa_cycle 0..22, done pulse on cycle 25.
//    0x400 reads 1 while busy, 0 after.
//  - During FEED: write 0x100 and 0x400 -> no a_wr, no restart, done still at cycle 25.
//    Assert rst mid-FEED -> busy=0 next cycle, no done.
//  - Unmapped 0x140, 0x304, 0x380, 0x408 -> write gives no strobe; read gives dataOut=0, rdValid=0.

Source files
------------

// File: rtl/tpu_mmio_responder.sv
// Host-bus slave for tpuv1: decodes word accesses into A/B/C memory strobes,
// serves C/status reads with write forwarding, and sequences the systolic array.
module tpu_mmio_responder #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int ADDRW   = 16,
  parameter int DATAW   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRW-1:0]         addr,
  input  logic                     r_w,
  input  logic [DATAW-1:0]         dataIn,
  output logic [DATAW-1:0]         dataOut,
  output logic                     rdValid,
  output logic                     a_wr,
  output logic                     b_wr,
  output logic                     c_wr,
  output logic [$clog2(DIM)-1:0]   wr_row,
  output logic                     wr_half,
  output logic [DATAW-1:0]         wr_data,
  output logic [$clog2(DIM)-1:0]   c_rd_row,
  output logic                     c_rd_half,
  input  logic [DATAW-1:0]         c_rdata,
  output logic                     sa_en,
  output logic [$clog2(3*DIM)-1:0] sa_cycle,
  output logic                     busy,
  output logic                     done
);

  localparam int RW = $clog2(DIM);
  localparam int CW = $clog2(3*DIM);
  localparam logic [ADDRW-1:0] A_BASE    = ADDRW'('h100);
  localparam logic [ADDRW-1:0] B_BASE    = ADDRW'('h200);
  localparam logic [ADDRW-1:0] C_BASE    = ADDRW'('h300);
  localparam logic [ADDRW-1:0] STAT_ADDR = ADDRW'('h400);
  localparam logic [CW-1:0]    LAST_CYC  = CW'(3*DIM-2);

  // A row packs DIM A/B elements into one word; a C row spans two words.
  if (DIM*BITS_AB != DATAW || DIM*BITS_C != 2*DATAW) begin : g_bad_cfg
    $error("tpu_mmio_responder: DIM/BITS_AB/BITS_C do not match DATAW");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DONE} state_t;
  typedef enum logic [1:0] {WK_NONE, WK_A, WK_B, WK_C} wr_kind_t;

  state_t          state, state_n;
  wr_kind_t        wr_kind;
  logic [CW-1:0]   sa_cycle_n;
  logic            start_q;
  logic [ADDRW-1:0] off_a, off_b, off_c;
  logic            aligned, hit_a, hit_b, hit_c, hit_stat, wr_ok;
  logic [RW-1:0]   row_ab, row_c;
  logic            half_c;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    off_a    = addr - A_BASE;
    off_b    = addr - B_BASE;
    off_c    = addr - C_BASE;
    aligned  = (addr[2:0] == 3'd0);
    hit_a    = aligned && (addr >= A_BASE) && (off_a < ADDRW'(8*DIM));
    hit_b    = aligned && (addr >= B_BASE) && (off_b < ADDRW'(8*DIM));
    hit_c    = aligned && (addr >= C_BASE) && (off_c < ADDRW'(16*DIM));
    hit_stat = (addr == STAT_ADDR);
    row_ab   = hit_a ? RW'(off_a >> 3) : RW'(off_b >> 3);
    row_c    = RW'(off_c >> 4);
    half_c   = off_c[3];
  end

  assign busy  = (state != ST_IDLE);
  assign sa_en = (state == ST_FEED);
  assign done  = (state == ST_DONE);
  assign wr_ok = r_w && !busy;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_kind <= WK_NONE;
      wr_row  <= '0;
      wr_half <= 1'b0;
      wr_data <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= wr_ok && hit_stat;
      wr_kind <= WK_NONE;
      if (wr_ok && (hit_a || hit_b || hit_c)) begin
        wr_kind <= hit_a ? WK_A : (hit_b ? WK_B : WK_C);
        wr_row  <= hit_c ? row_c : row_ab;
        wr_half <= hit_c && half_c;
        wr_data <= dataIn;
      end
    end
  end

  assign a_wr = (wr_kind == WK_A);
  assign b_wr = (wr_kind == WK_B);
  assign c_wr = (wr_kind == WK_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sa_cycle <= '0;
    end else begin
      state    <= state_n;
      sa_cycle <= sa_cycle_n;
    end
  end

  // A start registered while already in FEED (written the cycle before FEED) is ignored.
  always_comb begin
    state_n    = state;
    sa_cycle_n = '0;
    case (state)
      ST_IDLE: if (start_q) state_n = ST_FEED;
      ST_FEED: begin
        if (sa_cycle == LAST_CYC) state_n = ST_DONE;
        else                      sa_cycle_n = sa_cycle + 1'b1;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign c_rd_row  = row_c;
  assign c_rd_half = half_c;

  // A C write still sitting in the register wins over the stale memory word.
  always_comb begin
    dataOut = '0;
    rdValid = 1'b0;
    if (hit_c) begin
      dataOut = (c_wr && wr_row == row_c && wr_half == half_c) ? wr_data : c_rdata;
      rdValid = !r_w;
    end else if (hit_stat) begin
      dataOut = DATAW'(busy);
      rdValid = !r_w;
    end
  end

endmodule
